pio_poll_master: RTL and testbench

- Avalon-MM read master; the initiator end of the switch-input PIO slave.
- Periodically reads the PIO data register and debounces the sampled byte.
- On a confirmed change, presents the new value on a valid/ready stream to downstream logic, e.g. the seven-segment driver.

---
 rtl/pio_poll_master.sv | 140 ++++++++++++++
 tb/tb_pio_poll_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// Avalon-MM read master that polls a switch PIO, debounces the sampled field and
// streams confirmed changes. Define PIO_POLL_IRQ_EN to add rising-edge capture and irq.
module pio_poll_master #(
    parameter int DATA_W       = 8,
    parameter int POLL_DIV     = 1000,
    parameter int READ_LATENCY = 1,
    parameter int STABLE_N     = 4,
    parameter int PIO_ADDR     = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        address,
    output logic              read,
    input  logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_changed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] cur_value,
`ifdef PIO_POLL_IRQ_EN
    output logic              irq,
    input  logic [DATA_W-1:0] irq_mask,
    input  logic [DATA_W-1:0] edge_clr,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} state_t;

    localparam logic [15:0] TIMER_RELOAD = 16'(POLL_DIV - 1);
    localparam logic [1:0]  WAIT_LOAD    = 2'(READ_LATENCY - 1);
    localparam logic [3:0]  STABLE_MAX   = 4'(STABLE_N - 1);

    state_t            state;
    logic [15:0]       poll_timer;
    logic [1:0]        wait_cnt;
    logic [3:0]        stable_cnt;
    logic [3:0]        eval_cnt;
    logic [DATA_W-1:0] candidate;
    logic [DATA_W-1:0] sample;
    logic              commit;
`ifdef PIO_POLL_IRQ_EN
    logic [DATA_W-1:0] edge_capture;
`endif

    assign address   = 2'(PIO_ADDR);
    assign dbg_state = state;

    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^readdata[31:DATA_W];
        end
    endgenerate

    // After the EVAL update the candidate always equals the sample, so the
    // commit test can compare the sample directly against cur_value.
    always_comb begin
        eval_cnt = 4'd0;
        if (sample == candidate)
            eval_cnt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;
        commit = (state == EVAL) && (eval_cnt == STABLE_MAX) && (sample != cur_value);
    end

    // Stream handshake: a word transfers on any cycle with out_valid && out_ready;
    // out_valid then drops unless a commit reloads it, and out_data/out_changed only
    // change on a commit, so they hold while a word waits for out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            poll_timer  <= TIMER_RELOAD;
            wait_cnt    <= 2'd0;
            stable_cnt  <= 4'd0;
            candidate   <= '0;
            sample      <= '0;
            read        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_changed <= '0;
            cur_value   <= '0;
            overrun     <= 1'b0;
`ifdef PIO_POLL_IRQ_EN
            edge_capture <= '0;
            irq          <= 1'b0;
`endif
        end else begin
            // Free-running timer keeps the poll period exact regardless of read latency.
            poll_timer <= (poll_timer == 16'd0) ? TIMER_RELOAD : poll_timer - 16'd1;
            read       <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_timer == 16'd0) begin
                        state <= REQ;
                        read  <= 1'b1;
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        sample <= readdata[DATA_W-1:0];
                        state  <= EVAL;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                EVAL: begin
                    candidate  <= sample;
                    stable_cnt <= eval_cnt;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                out_changed <= sample ^ cur_value;
                out_data    <= sample;
                cur_value   <= sample;
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (commit && out_valid && !out_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

`ifdef PIO_POLL_IRQ_EN
            edge_capture <= (edge_capture & ~edge_clr) | (commit ? (sample & ~cur_value) : '0);
            irq          <= |(edge_capture & irq_mask);
`endif
        end
    end

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: bus slave model, directed scenarios, randomized traffic
// and a cycle-level reference model built from a sample-history debounce rule.
module tb_pio_poll_master;

    localparam int DATA_W       = 8;
    localparam int POLL_DIV     = 10;
    localparam int READ_LATENCY = 1;
    localparam int STABLE_N     = 4;
    localparam int PIO_ADDR     = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        address;
    logic              read;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_changed;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              overrun;
    logic              overrun_clr = 1'b0;
    logic [DATA_W-1:0] cur_value;
    logic [1:0]        dbg_state;
`ifdef PIO_POLL_IRQ_EN
    logic              irq;
    logic [DATA_W-1:0] irq_mask = '0;
    logic [DATA_W-1:0] edge_clr = '0;
`endif

    pio_poll_master #(
        .DATA_W(DATA_W), .POLL_DIV(POLL_DIV), .READ_LATENCY(READ_LATENCY),
        .STABLE_N(STABLE_N), .PIO_ADDR(PIO_ADDR)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
        .out_data(out_data), .out_changed(out_changed), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr),
        .cur_value(cur_value),
`ifdef PIO_POLL_IRQ_EN
        .irq(irq), .irq_mask(irq_mask), .edge_clr(edge_clr),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Avalon slave model (fixed latency, junk otherwise) ----------------
    logic [DATA_W-1:0] sw_value = '0;
    logic [31:0]       dq [READ_LATENCY];
    logic              vq [READ_LATENCY];
    logic [31:0]       junk;

    always @(posedge clk) begin
        junk  <= $urandom;
        dq[0] <= {24'($urandom), sw_value};
        vq[0] <= read;
        for (int i = 1; i < READ_LATENCY; i++) begin
            dq[i] <= dq[i-1];
            vq[i] <= vq[i-1];
        end
    end
    assign readdata = (vq[READ_LATENCY-1] === 1'b1) ? dq[READ_LATENCY-1] : junk;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: a value commits when the last STABLE_N polled samples all equal it
    // and it differs from the last committed value; evaluation lands READ_LATENCY+1
    // cycles after the read strobe cycle.
    logic [DATA_W-1:0] exp_q[$];
    logic              pend = 1'b0;
    int                eval_at = 0;
    logic              m_valid = 1'b0;
    logic              m_ovr = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic [DATA_W-1:0] m_changed = '0;
    logic [DATA_W-1:0] m_cur = '0;
`ifdef PIO_POLL_IRQ_EN
    logic [DATA_W-1:0] m_edge = '0;
    logic              m_irq = 1'b0;
`endif
    int   rises = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin : monitor
        logic              exp_read;
        logic              commit;
        logic              stable;
        logic              ovr_set;
        logic [DATA_W-1:0] v;
        int                n;
        exp_read = (cyc != 0) && (cyc % POLL_DIV == 0);
        check("read", 32'(read), 32'(exp_read));
        check("address", 32'(address), 32'(PIO_ADDR));
        check("stream", 32'({out_valid, out_data, out_changed}), 32'({m_valid, m_data, m_changed}));
        check("cur_value", 32'(cur_value), 32'(m_cur));
        check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef PIO_POLL_IRQ_EN
        check("irq", 32'(irq), 32'(m_irq));
`endif
        if (out_valid && !prev_valid) rises++;
        prev_valid = out_valid;

        if (reset) begin
            exp_q.delete();
            pend = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
            m_data = '0; m_changed = '0; m_cur = '0;
`ifdef PIO_POLL_IRQ_EN
            m_edge = '0; m_irq = 1'b0;
`endif
        end else begin
            commit = 1'b0;
            v = '0;
            if (pend && cyc == eval_at) begin
                pend = 1'b0;
                n = exp_q.size();
                v = exp_q[n-1];
                stable = (n >= STABLE_N);
                if (stable)
                    for (int i = 1; i < STABLE_N; i++)
                        if (exp_q[n-1-i] != v) stable = 1'b0;
                commit = stable && (v != m_cur);
            end
            if (exp_read) begin
                exp_q.push_back(sw_value);
                if (exp_q.size() > 16) void'(exp_q.pop_front());
                pend = 1'b1;
                eval_at = cyc + READ_LATENCY + 1;
            end
            ovr_set = commit && m_valid && !out_ready;
`ifdef PIO_POLL_IRQ_EN
            m_irq  = |(m_edge & irq_mask);
            m_edge = (m_edge & ~edge_clr) | (commit ? (v & ~m_cur) : '0);
`endif
            if (commit) begin
                m_changed = v ^ m_cur;
                m_data    = v;
                m_cur     = v;
                m_valid   = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_read(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (read === 1'b1) seen = 1'b1;
        end
        check("read_timeout", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic polls(input int n);
        for (int i = 0; i < n; i++) wait_read(3 * POLL_DIV);
        repeat (READ_LATENCY + 3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        int gap;
        logic seen;
        logic [DATA_W-1:0] pick[5];

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle polling of a zero input: no stream activity
        r0 = rises;
        repeat (4 * POLL_DIV) @(posedge clk);
        @(negedge clk);
        check("idle_commits", 32'(rises - r0), 32'd0);
        check("idle_cur", 32'(cur_value), 32'd0);
        @(posedge clk); #1;

        // Step 0x00 -> 0xA5
        r0 = rises;
        sw_value = 8'hA5;
        polls(6);
        @(negedge clk);
        check("a5_commits", 32'(rises - r0), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_changed", 32'(out_changed), 32'hA5);
        check("a5_cur", 32'(cur_value), 32'hA5);
        @(posedge clk); #1;

        // Toggle 0x01/0x00 per poll, then settle on 0x01
        r0 = rises;
        for (int i = 0; i < 8; i++) begin
            sw_value = (i % 2 == 0) ? 8'h01 : 8'h00;
            wait_read(3 * POLL_DIV);
        end
        repeat (READ_LATENCY + 3) @(posedge clk);
        @(negedge clk);
        check("toggle_commits", 32'(rises - r0), 32'd0);
        @(posedge clk); #1;
        sw_value = 8'h01;
        polls(5);
        @(negedge clk);
        check("settle_commits", 32'(rises - r0), 32'd1);
        check("settle_data", 32'(out_data), 32'h01);
        @(posedge clk); #1;

        // Back-to-back commits with the sink stalled
        out_ready = 1'b0;
        sw_value = 8'h0F;
        polls(5);
        sw_value = 8'hF0;
        polls(5);
        @(negedge clk);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_data", 32'(out_data), 32'hF0);
        check("ovr_changed", 32'(out_changed), 32'hFF);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset while the read is outstanding
        sw_value = 8'h3C;
        wait_read(3 * POLL_DIV);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * POLL_DIV && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (read === 1'b1) seen = 1'b1;
        end
        check("rst_first_read", 32'(gap), 32'(POLL_DIV));
        check("rst_cur", 32'(cur_value), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

`ifdef PIO_POLL_IRQ_EN
        // Rising-edge capture and masking
        do_reset(2);
        irq_mask = 8'h80;
        sw_value = 8'h81;
        polls(5);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        @(posedge clk); #1;
        edge_clr = 8'h80;
        @(posedge clk); #1;
        edge_clr = 8'h00;
        repeat (3) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        @(posedge clk); #1;
        irq_mask = 8'h01;
        repeat (2) @(negedge clk);
        check("irq_bit0_left", 32'(irq), 32'd1);
        @(posedge clk); #1;
`endif

        // Randomized traffic against the reference model
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'hA5; pick[3] = 8'h5A; pick[4] = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 59) == 0) begin
                pick[4]  = 8'($urandom);
                sw_value = pick[$urandom_range(0, 4)];
            end
`ifdef PIO_POLL_IRQ_EN
            edge_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 99) == 0) irq_mask = 8'($urandom);
`endif
            @(posedge clk); #1;
        end
        reset = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
